// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and imem request/valid fetch stage feeding the decoder; FETCH_RETIRE_CNT_EN adds a saturating retire counter
module fetch_unit #(
  parameter int PC_W = 10,
  parameter int INSTR_W = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic               format,
  output logic [3:0]         opcode,
  output logic               sign,
  output logic [7:0]         imm,
  input  logic               branch,
  input  logic               jump,
  input  logic               halt,
  input  logic               branch_cond,
  input  logic [PC_W-1:0]    jump_addr,
  input  logic               stall,
  output logic [PC_W-1:0]    pc,
  output logic               halted
`ifdef FETCH_RETIRE_CNT_EN
  ,
  output logic [15:0]        retired
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;
  state_t state, state_d;
  logic [PC_W-1:0] pc_d;
  logic [INSTR_W-1:0] instr, instr_d;
  logic restart, advance;
  assign restart = start && (state == IDLE || state == HALTED);
  assign advance = state == EXEC && !halt && !stall;
  assign imem_req = state == FETCH;
  assign imem_addr = pc;
  assign instr_valid = state == EXEC;
  assign halted = state == HALTED;
  assign format = instr[8];
  assign opcode = instr[7:4];
  assign sign = instr[3];
  assign imm = instr[7:0];
  always_comb begin
    state_d = state;
    pc_d = pc;
    instr_d = instr;
    case (state)
      IDLE, HALTED: if (restart) begin
        state_d = FETCH;
        pc_d = RESET_PC;
      end
      FETCH: if (imem_valid) begin
        state_d = EXEC;
        instr_d = imem_rdata;
      end
      EXEC: if (halt) state_d = HALTED;
      else if (!stall) begin
        state_d = FETCH;
        pc_d = jump ? jump_addr
             : (branch && branch_cond) ? pc + {{(PC_W-4){instr[3]}}, instr[3:0]}
             : pc + PC_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      instr <= instr_d;
    end
  end
`ifdef FETCH_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || restart) retired <= '0;
    else if (advance && retired != 16'hFFFF) retired <= retired + 16'd1;
  end
`else
  logic unused_advance;
  assign unused_advance = advance;
`endif
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction decoder.
- Owns the program counter and runs a request/valid handshake with instruction memory.
- Latches each fetched instruction and presents its format/opcode/sign/operand fields to the decoder.
- Consumes the decoder's branch/jump/halt outputs to pick the next PC; stops cleanly on halt.

Parameters:
- PC_W, 10, program counter and instruction-memory address width.
- INSTR_W, 9, instruction width; fixed layout: [8] format, [7:4] opcode, [3] sign, [3:0] offset, [7:0] imm.
- RESET_PC, 0, PC value loaded on reset and on restart.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  leave IDLE/HALTED and begin fetching at RESET_PC.
- imem_req  out  1  fetch request, held until imem_valid.
- imem_addr  out  PC_W  fetch address, equals pc while imem_req=1.
- imem_valid  in  1  instruction-memory data valid.
- imem_rdata  in  INSTR_W  instruction word.
- instr_valid  out  1  latched instruction is on the decoder outputs.
- format  out  1  instr[8].
- opcode  out  4  instr[7:4].
- sign  out  1  instr[3].
- imm  out  8  instr[7:0].
- branch  in  1  from decoder.
- jump  in  1  from decoder.
- halt  in  1  from decoder.
- branch_cond  in  1  datapath condition; a branch is taken only when branch=1 and branch_cond=1.
- jump_addr  in  PC_W  absolute jump target from the register file.
- stall  in  1  datapath busy; freeze the current instruction.
- pc  out  PC_W  current PC.
- halted  out  1  core halted.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE and pc to RESET_PC.
  - imem_req, instr_valid and halted go to 0; the instruction latch goes to 0.
  - Reset wins over every other input, including mid-handshake: imem_req is 0 on the cycle after the reset edge.
- States: IDLE, FETCH, EXEC, HALTED.
- IDLE:
  - All outputs are idle.
  - start=1 moves to FETCH with pc=RESET_PC.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - On an edge with imem_valid=1, imem_rdata is latched and the state moves to EXEC.
  - Otherwise the block stays in FETCH with the request held and the address unchanged.
- EXEC:
  - instr_valid=1 and the field outputs are driven from the latch; imem_req=0.
  - Decoder outputs are sampled at the end of the cycle. Priority: halt > stall > jump > taken branch > sequential.
  - halt=1: go to HALTED, set halted=1, pc unchanged.
  - stall=1: remain in EXEC, instr_valid stays 1, pc and latch unchanged.
  - jump=1: pc <= jump_addr, go to FETCH.
  - Taken branch: pc <= pc + sign-extended instr[3:0] (range −8..+7), go to FETCH.
  - Otherwise: pc <= pc + 1, go to FETCH.
- HALTED:
  - halted=1, imem_req=0, instr_valid=0.
  - start=1 clears halted, sets pc=RESET_PC and goes to FETCH.
- Latency: the minimum instruction period is 2 cycles (FETCH with same-cycle valid, then EXEC).
- Arithmetic:
  - All PC arithmetic is modulo 2^PC_W.
  - pc+1 at all-ones wraps to 0.
  - A branch offset below 0 wraps around.
- Boundary conditions:
  - imem_valid outside FETCH is ignored.
  - start outside IDLE/HALTED is ignored.
  - branch=1 with branch_cond=0 falls through to sequential.
  - jump and branch together: jump wins.
  - Field outputs are don't-care but stable (hold the last latch) when instr_valid=0.

Optional Feature:
- Macro FETCH_RETIRE_CNT_EN.
- Defined:
  - Adds output retired (16 bits), reset to 0.
  - Increments by 1 on every EXEC exit that is not stall or halt.
  - Saturates at 16'hFFFF.
  - Cleared on restart via start.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, start, imem_valid always 1 with no redirects -> imem_addr steps 0,1,2,3; instr_valid high every second cycle.
- imem_valid delayed 3 cycles at pc=5 -> imem_req and imem_addr=5 held 3 cycles; EXEC follows the valid cycle; next fetch at 6.
- At pc=10: instr offset=4'b1101 with branch=1, cond=1 -> next pc=7. Same with cond=0 -> next pc=11.
- jump=1 and branch=1 together with jump_addr=10'h3F0 -> next pc=0x3F0. At pc=0x3FF sequential -> next pc=0.
- stall high 4 cycles in EXEC, then halt=1 -> instr_valid held 5 cycles, pc unchanged, halted=1, no further imem_req; start -> fetch from 0.
- rst_n low during FETCH wait -> imem_req=0 the next cycle, pc=0, IDLE; with FETCH_RETIRE_CNT_EN, 3 retired instructions -> retired=3.
